// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - two-requester valid/ready arbiter sharing one 8-bit ALU

module alu_8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [3:0] op_i,
    output logic [7:0] result_o,
    output logic       zero_o,
    output logic       neg_o,
    output logic       ovf_o,
    output logic       err_o
);
    logic [7:0] sum;
    logic [7:0] diff;

    assign sum  = a_i + b_i;
    assign diff = b_i - a_i;

    always_comb begin
        result_o = 8'h00;
        ovf_o    = 1'b0;
        err_o    = 1'b0;
        case (op_i)
            4'd0: begin
                result_o = sum;
                ovf_o    = (a_i[7] == b_i[7]) && (sum[7] != a_i[7]);
            end
            4'd1: begin
                result_o = diff;
                ovf_o    = (a_i[7] != b_i[7]) && (diff[7] != b_i[7]);
            end
            4'd2:  result_o = a_i + 8'd1;
            4'd5:  result_o = {7'd0, (a_i == b_i)};
            4'd6:  result_o = {b_i[6:0], 1'b0};
            4'd7:  result_o = {b_i[7], b_i[7:1]};
            4'd8:  result_o = ~a_i;
            4'd9:  result_o = a_i & b_i;
            4'd10: result_o = a_i | b_i;
            4'd11: result_o = ~(a_i & b_i);
            4'd12: result_o = {a_i[6:0], a_i[7]};
            4'd13: result_o = {a_i[0], a_i[7:1]};
            default: err_o  = 1'b1;
        endcase
    end

    assign zero_o = (result_o == 8'h00);
    assign neg_o  = result_o[7];
endmodule

module alu_req_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned FAIR   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [2:0]        rsp_flags,
    output logic              rsp_err,
    output logic              busy
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [2:0]        flags_q, flags_d;
    logic              err_q, err_d;

    logic              grant;
    logic              grant_vld;
    logic [7:0]        alu_result;
    logic              alu_zero, alu_neg, alu_ovf, alu_err;

    alu_8 u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_result),
        .zero_o   (alu_zero),
        .neg_o    (alu_neg),
        .ovf_o    (alu_ovf),
        .err_o    (alu_err)
    );

    // Grant looks only at valids and the round-robin pointer, never at payload.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant     = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = (FAIR != 0) ? rr_ptr_q : 1'b0;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = !rst && (state_q == S_IDLE) && grant_vld && !grant;
    assign req1_ready = !rst && (state_q == S_IDLE) && grant_vld &&  grant;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req0_valid && req0_ready) begin
                    owner_d = 1'b0;
                    a_d     = req0_a;
                    b_d     = req0_b;
                    op_d    = req0_op;
                    state_d = S_EXEC;
                end else if (req1_valid && req1_ready) begin
                    owner_d = 1'b1;
                    a_d     = req1_a;
                    b_d     = req1_b;
                    op_d    = req1_op;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = alu_result;
                flags_d  = {alu_zero, alu_neg, alu_ovf};
                err_d    = alu_err;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = S_IDLE;
                    if (FAIR != 0) begin
                        rr_ptr_d = ~owner_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= 1'b0;
            owner_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

    assign rsp0_valid = (state_q == S_RESP) && !owner_q;
    assign rsp1_valid = (state_q == S_RESP) &&  owner_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - scoreboard bench for alu_req_arbiter (fair and fixed-priority instances)

module tb_alu_req_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0] req0_op = '0, req1_op = '0;
    logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;

    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, busy;
    logic [7:0] rsp_result;
    logic [2:0] rsp_flags;

    logic       f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_rsp_err, f_busy;
    logic [7:0] f_rsp_result;
    logic [2:0] f_rsp_flags;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic       owner;
        logic [7:0] res;
        logic [2:0] fl;
        logic       err;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_req_arbiter #(.DATA_W(8), .OP_W(4), .FAIR(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
    );

    alu_req_arbiter #(.DATA_W(8), .OP_W(4), .FAIR(0)) dut_fixed (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(f_rsp_result), .rsp_flags(f_rsp_flags), .rsp_err(f_rsp_err), .busy(f_busy)
    );

    function automatic exp_t model(input logic owner, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        exp_t e;
        int   sa, sb, s;
        logic [7:0] r;
        logic v, er;
        sa = $signed(a);
        sb = $signed(b);
        v  = 1'b0;
        er = 1'b0;
        r  = 8'h00;
        case (op)
            4'd0: begin s = sa + sb; r = 8'(a + b); v = (s > 127) || (s < -128); end
            4'd1: begin s = sb - sa; r = 8'(b - a); v = (s > 127) || (s < -128); end
            4'd2: r = 8'(a + 8'd1);
            4'd5: r = (a == b) ? 8'd1 : 8'd0;
            4'd6: r = 8'(b << 1);
            4'd7: r = 8'($signed(b) >>> 1);
            4'd8: r = ~a;
            4'd9: r = a & b;
            4'd10: r = a | b;
            4'd11: r = ~(a & b);
            4'd12: r = 8'((a << 1) | (a >> 7));
            4'd13: r = 8'((a >> 1) | (a << 7));
            default: er = 1'b1;
        endcase
        e.owner = owner;
        e.res   = r;
        e.fl    = {(r == 8'h00), r[7], v};
        e.err   = er;
        return e;
    endfunction

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin
        exp_t e, got;
        if (!rst) begin
            if (req0_valid && req0_ready) sb_q.push_back(model(1'b0, req0_a, req0_b, req0_op));
            if (req1_valid && req1_ready) sb_q.push_back(model(1'b1, req1_a, req1_b, req1_op));
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                n_vec++;
                got = '{owner: rsp1_valid, res: rsp_result, fl: rsp_flags, err: rsp_err};
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected_rsp: got %h, required no response", got);
                end else begin
                    e = sb_q.pop_front();
                    if (got !== e || (rsp0_valid & rsp1_valid) !== 1'b0) begin
                        n_err++;
                        $display("FAIL sb_rsp: got owner=%0d res=%h fl=%b err=%b both=%b, required owner=%0d res=%h fl=%b err=%b",
                                 got.owner, got.res, got.fl, got.err, rsp0_valid & rsp1_valid, e.owner, e.res, e.fl, e.err);
                    end
                end
            end
        end
    end

    task automatic issue(input logic who, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        bit ok = 0;
        @(posedge clk); #1;
        if (!who) begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
        else      begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            ok = who ? req1_ready : req0_ready;
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL issue_timeout: req%0d never ready, required ready within 30 cycles", who);
        end
        @(posedge clk); #1;
        if (!who) req0_valid = 0; else req1_valid = 0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL idle_timeout: busy=%b, required 0 within 30 cycles", busy);
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1 rst = 1;
        sb_q.delete();
        @(posedge clk); #1 rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flags, rsp_err, busy} !== 16'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b res=%h fl=%b err=%b busy=%b, required all 0",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flags, rsp_err, busy);
        end
        n_vec++;
        if ({f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_rsp_result, f_rsp_flags, f_rsp_err, f_busy} !== 16'h0) begin
            n_err++;
            $display("FAIL reset_outputs_fixed: got nonzero outputs, required all 0");
        end
        @(posedge clk); #1 rst = 0;
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 8'h7F; req0_b = 8'h01; req0_op = 4'd0;
        @(negedge clk);
        n_vec++;
        if (req0_ready !== 1'b1) begin n_err++; $display("FAIL t1_ready: got %b, required 1", req0_ready); end
        @(posedge clk); #1 req0_valid = 0;
        @(negedge clk);
        n_vec++;
        if ({busy, rsp0_valid, req0_ready} !== 3'b100) begin
            n_err++; $display("FAIL t1_exec: busy/rsp0_valid/ready got %b, required 100", {busy, rsp0_valid, req0_ready});
        end
        @(negedge clk);
        n_vec++;
        if ({rsp0_valid, rsp1_valid, rsp_result, rsp_flags, rsp_err} !== {1'b1, 1'b0, 8'h80, 3'b011, 1'b0}) begin
            n_err++;
            $display("FAIL t1_rsp: got v0=%b v1=%b res=%h fl=%b err=%b, required 1 0 80 011 0",
                     rsp0_valid, rsp1_valid, rsp_result, rsp_flags, rsp_err);
        end
        wait_idle();
    endtask

    localparam logic [20:0] OPS [17] = '{
        {1'b0, 8'hFF, 8'h01, 4'd0},  {1'b1, 8'h01, 8'h80, 4'd1},  {1'b0, 8'h80, 8'h80, 4'd0},
        {1'b1, 8'hF0, 8'h10, 4'd1},  {1'b0, 8'h7F, 8'h00, 4'd2},  {1'b1, 8'h33, 8'h33, 4'd5},
        {1'b0, 8'h12, 8'h81, 4'd6},  {1'b1, 8'h00, 8'h81, 4'd7},  {1'b0, 8'h5A, 8'h00, 4'd8},
        {1'b1, 8'hF0, 8'h3C, 4'd9},  {1'b0, 8'hF0, 8'h0C, 4'd10}, {1'b1, 8'hFF, 8'hFF, 4'd11},
        {1'b0, 8'h81, 8'h00, 4'd12}, {1'b1, 8'h01, 8'h00, 4'd13}, {1'b0, 8'h01, 8'h02, 4'd4},
        {1'b1, 8'h01, 8'h02, 4'd14}, {1'b0, 8'hAA, 8'h55, 4'd15}
    };

    task automatic test_ops();
        logic [20:0] v;
        for (int i = 0; i < 17; i++) begin
            v = OPS[i];
            issue(v[20], v[19:12], v[11:4], v[3:0]);
            wait_idle();
        end
    endtask

    task automatic test_fair();
        int gcnt = 0;
        int first = -1;
        reset_pulse();
        req0_a = 8'h11; req0_b = 8'h22; req0_op = 4'd0;
        req1_a = 8'h33; req1_b = 8'h44; req1_op = 4'd10;
        req0_valid = 1; req1_valid = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_vec++;
            if (req0_ready && req1_ready) begin n_err++; $display("FAIL t2_both_ready: cycle %0d got 11, required at most one", c); end
            if (req0_ready || req1_ready) begin
                if (first < 0) first = c;
                n_vec++;
                if (req1_ready !== 1'(gcnt % 2) || c !== first + 3 * gcnt) begin
                    n_err++;
                    $display("FAIL t2_grant: grant %0d got req%0d at cycle %0d, required req%0d at cycle %0d",
                             gcnt, req1_ready, c, gcnt % 2, first + 3 * gcnt);
                end
                gcnt++;
            end
        end
        @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
        n_vec++;
        if (gcnt !== 4 || first !== 0) begin n_err++; $display("FAIL t2_count: got %0d grants first at %0d, required 4 at 0", gcnt, first); end
        wait_idle();
    endtask

    task automatic test_fixed();
        int c0 = 0;
        int c1 = 0;
        reset_pulse();
        req0_a = 8'h05; req0_b = 8'h06; req0_op = 4'd9;
        req1_a = 8'h07; req1_b = 8'h08; req1_op = 4'd9;
        req0_valid = 1; req1_valid = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (f_req0_ready) c0++;
            if (f_req1_ready) c1++;
        end
        @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
        n_vec++;
        if (c0 !== 4 || c1 !== 0) begin n_err++; $display("FAIL t3_fixed: got req0 %0d req1 %0d grants, required 4 and 0", c0, c1); end
        wait_idle();
        reset_pulse();
    endtask

    task automatic test_hold();
        bit ok = 0;
        rsp1_ready = 0;
        issue(1'b1, 8'd42, 8'd42, 4'd5);
        req0_valid = 1; req0_a = 8'h0F; req0_b = 8'h3C; req0_op = 4'd9;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (i > 0) @(negedge clk);
            ok = rsp1_valid;
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            n_vec++;
            if ({rsp1_valid, rsp0_valid, rsp_result, rsp_flags, rsp_err, req0_ready, req1_ready} !== {1'b1, 1'b0, 8'h01, 3'b000, 1'b0, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL t4_hold: cycle %0d got v1=%b v0=%b res=%h fl=%b err=%b r0=%b r1=%b, required 1 0 01 000 0 0 0",
                         c, rsp1_valid, rsp0_valid, rsp_result, rsp_flags, rsp_err, req0_ready, req1_ready);
            end
        end
        @(posedge clk); #1 rsp1_ready = 1;
        @(negedge clk);
        n_vec++;
        if (req0_ready !== 1'b0) begin n_err++; $display("FAIL t4_ready_in_resp: got %b, required 0", req0_ready); end
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = req0_ready;
        end
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL t4_waiting_req0: never accepted, required accept after rsp1 taken"); end
        @(posedge clk); #1 req0_valid = 0;
        wait_idle();
    endtask

    task automatic test_invalid();
        bit ok = 0;
        issue(1'b0, 8'h05, 8'h09, 4'b0011);
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = rsp0_valid;
        end
        n_vec++;
        if (!ok || {rsp_result, rsp_flags, rsp_err} !== {8'h00, 3'b100, 1'b1}) begin
            n_err++;
            $display("FAIL t5_invalid: got v=%b res=%h fl=%b err=%b, required 1 00 100 1", ok, rsp_result, rsp_flags, rsp_err);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 8'h10, 8'h20, 4'd0);
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL t6_exec: busy got %b, required 1", busy); end
        req0_valid = 1;
        rst = 1;
        sb_q.delete();
        #1;
        n_vec++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flags, rsp_err, busy} !== 16'h0) begin
            n_err++; $display("FAIL t6_reset_outputs: got r0=%b busy=%b res=%h, required all 0", req0_ready, busy, rsp_result);
        end
        @(posedge clk); #1 req0_valid = 0;
        @(posedge clk); #1 rst = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_vec++;
            if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
                n_err++; $display("FAIL t6_no_rsp: cycle %0d got v0=%b v1=%b busy=%b, required 000", c, rsp0_valid, rsp1_valid, busy);
            end
        end
        issue(1'b0, 8'h10, 8'h20, 4'd0);
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 100us");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_ops();
        test_fair();
        test_fixed();
        test_hold();
        test_invalid();
        test_reset_mid();
        repeat (2) @(negedge clk);
        n_vec++;
        if (sb_q.size() !== 0) begin n_err++; $display("FAIL sb_leftover: got %0d pending, required 0", sb_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
